// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner with hex decode and shadowed load.
// Optional blink support is compiled in when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
`ifdef SEVEN_SEG_BLINK_EN
    ,
    parameter int BLINK_DIV   = 50
`endif
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] VALUES,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   EN,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   BLINK,
`endif
    output logic [NUM_DIGITS-1:0]   SEL,
    output logic [7:0]              DIGIT
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    // Segment pattern {g,f,e,d,c,b,a}, active low, for one hex nibble.
    function automatic logic [6:0] hex_font(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]        r_refresh_cnt;
    logic [IDX_W-1:0]        r_scan_idx;
    logic [4*NUM_DIGITS-1:0] r_values_sh;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [NUM_DIGITS-1:0]   r_en_sh;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic [7:0]              r_digit;

    logic                    w_tick;
    logic                    w_idx_wrap;
    logic [NUM_DIGITS-1:0]   w_blink_mask;
    logic [NUM_DIGITS-1:0]   w_hit;
    logic [NUM_DIGITS-1:0]   w_sel_next;
    logic [7:0]              w_seg_on;
    logic [7:0]              w_digit_next;

    assign w_tick     = (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    // Any index at or beyond the last digit wraps, so a corrupted index self-heals.
    assign w_idx_wrap = (r_scan_idx >= IDX_W'(NUM_DIGITS - 1));

    // Slot timer and digit index.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_refresh_cnt <= {CNT_W{1'b0}};
            r_scan_idx    <= {IDX_W{1'b0}};
        end else if (w_tick) begin
            r_refresh_cnt <= {CNT_W{1'b0}};
            r_scan_idx    <= w_idx_wrap ? {IDX_W{1'b0}} : (r_scan_idx + IDX_W'(1));
        end else begin
            r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
            r_scan_idx    <= r_scan_idx;
        end
    end

    // Shadow capture of the display contents.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_values_sh <= {(4*NUM_DIGITS){1'b0}};
            r_dp_sh     <= {NUM_DIGITS{1'b0}};
            r_en_sh     <= {NUM_DIGITS{1'b0}};
        end else if (LOAD) begin
            r_values_sh <= VALUES;
            r_dp_sh     <= DP;
            r_en_sh     <= EN;
        end else begin
            r_values_sh <= r_values_sh;
            r_dp_sh     <= r_dp_sh;
            r_en_sh     <= r_en_sh;
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int BC_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [NUM_DIGITS-1:0] r_blink_sh;
    logic [BC_W-1:0]       r_scan_cnt;
    logic                  r_blink_phase;

    // Blink attribute shadow, captured alongside the other digit data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_blink_sh <= {NUM_DIGITS{1'b0}};
        end else if (LOAD) begin
            r_blink_sh <= BLINK;
        end else begin
            r_blink_sh <= r_blink_sh;
        end
    end

    // Scan counter and blink phase; phase starts visible and flips every BLINK_DIV scans.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_scan_cnt    <= {BC_W{1'b0}};
            r_blink_phase <= 1'b1;
        end else if (w_tick && w_idx_wrap) begin
            if (r_scan_cnt >= BC_W'(BLINK_DIV - 1)) begin
                r_scan_cnt    <= {BC_W{1'b0}};
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_scan_cnt    <= r_scan_cnt + BC_W'(1);
                r_blink_phase <= r_blink_phase;
            end
        end else begin
            r_scan_cnt    <= r_scan_cnt;
            r_blink_phase <= r_blink_phase;
        end
    end

    assign w_blink_mask = r_blink_phase ? {NUM_DIGITS{1'b0}} : r_blink_sh;
`else
    assign w_blink_mask = {NUM_DIGITS{1'b0}};
`endif

    // Next anode/segment pattern; at most one digit can match the index, so OR-merging is safe.
    always_comb begin
        w_hit    = {NUM_DIGITS{1'b0}};
        w_seg_on = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_hit[i] = (r_scan_idx == IDX_W'(i)) && r_en_sh[i] && !w_blink_mask[i];
            w_seg_on = w_seg_on |
                       (w_hit[i] ? {r_dp_sh[i], ~hex_font(r_values_sh[4*i +: 4])} : 8'h00);
        end
        w_sel_next   = ~w_hit;
        w_digit_next = ~w_seg_on;
    end

    // Registered pin drivers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sel   <= {NUM_DIGITS{1'b1}};
            r_digit <= 8'hFF;
        end else begin
            r_sel   <= w_sel_next;
            r_digit <= w_digit_next;
        end
    end

    assign SEL   = r_sel;
    assign DIGIT = r_digit;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Scoreboard bench for seven_seg_scan_mux: a time-based reference model queues the
// expected pins for each cycle and an independent monitor compares them.
module tb_seven_seg_scan_mux;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BD = 2;
    localparam int VW = 4 * ND;
`ifdef SEVEN_SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          LOAD = 1'b0;
    logic [VW-1:0] VALUES = '0;
    logic [ND-1:0] DP = '0;
    logic [ND-1:0] EN = '0;
    logic [ND-1:0] tb_blink = '0;
    logic [ND-1:0] SEL;
    logic [7:0]    DIGIT;

    seven_seg_scan_mux #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD)
`ifdef SEVEN_SEG_BLINK_EN
        ,
        .BLINK_DIV  (BD)
`endif
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (LOAD),
        .VALUES(VALUES),
        .DP    (DP),
        .EN    (EN),
`ifdef SEVEN_SEG_BLINK_EN
        .BLINK (tb_blink),
`endif
        .SEL   (SEL),
        .DIGIT (DIGIT)
    );

    always #5 CLK = ~CLK;

    logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: cycles since reset plus a copy of the latched display contents.
    int            m_n = 0;
    logic [3:0]    m_val [ND];
    logic [ND-1:0] m_dp = '0;
    logic [ND-1:0] m_en = '0;
    logic [ND-1:0] m_bl = '0;

    logic [ND+7:0] exp_q [$];
    int            vectors = 0;
    int            errors  = 0;

    function automatic void model_out(output logic [ND-1:0] es, output logic [7:0] ed);
        int slot;
        int scan;
        bit vis;
        slot = (m_n / RD) % ND;
        scan = m_n / (RD * ND);
        vis  = m_en[slot] && !(BLINK_ON && m_bl[slot] && (((scan / BD) % 2) == 1));
        es = '1;
        ed = 8'hFF;
        if (vis) begin
            es[slot] = 1'b0;
            ed = {~m_dp[slot], font_tbl[m_val[slot]][6:0]};
        end
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [VW-1:0] v,
                        input logic [ND-1:0] dp, input logic [ND-1:0] en,
                        input logic [ND-1:0] bl);
        logic [ND-1:0] es;
        logic [7:0]    ed;
        @(negedge CLK);
        RESET = rst; LOAD = ld; VALUES = v; DP = dp; EN = en; tb_blink = bl;
        if (rst) begin
            es = '1;
            ed = 8'hFF;
        end else begin
            model_out(es, ed);
        end
        exp_q.push_back({es, ed});
        if (rst) begin
            m_n = 0;
            for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
            m_dp = '0; m_en = '0; m_bl = '0;
        end else begin
            m_n++;
            if (ld) begin
                for (int i = 0; i < ND; i++) m_val[i] = v[4*i +: 4];
                m_dp = dp; m_en = en; m_bl = bl;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, VW'($urandom), ND'($urandom), ND'($urandom), ND'($urandom));
    endtask

    // Monitor: the pins are presented every cycle; compare just after each edge.
    initial begin
        logic [ND+7:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({SEL, DIGIT} !== e) begin
                    errors++;
                    $display("FAIL scan_out t=%0t: SEL=%b DIGIT=%h, expected SEL=%b DIGIT=%h",
                             $time, SEL, DIGIT, e[ND+7:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < ND; i++) m_val[i] = 4'h0;

        // Reset, then no load: everything blank while the index free-runs.
        step(1'b1, 1'b0, '0, '0, '0, '0);
        step(1'b1, 1'b0, '0, '0, '0, '0);
        idle(40);

        // Full display of 3B1F, no decimal points.
        step(1'b0, 1'b1, 16'h3B1F, 4'b0000, 4'b1111, 4'b0000);
        idle(2 * RD * ND);

        // Partial enable with dp on digit 0.
        step(1'b0, 1'b1, 16'h3B1F, 4'b0001, 4'b0101, 4'b0000);
        idle(2 * RD * ND);

        // Load exactly on the tick that ends slot 1.
        while (!((m_n % RD) == RD - 1 && ((m_n / RD) % ND) == 1)) idle(1);
        step(1'b0, 1'b1, 16'hA5C7, 4'b0110, 4'b1111, 4'b0000);
        idle(RD * ND);

        // Reset mid-slot 2, then reload and rescan.
        while (!((m_n % RD) == 1 && ((m_n / RD) % ND) == 2)) idle(1);
        step(1'b1, 1'b0, '0, '0, '0, '0);
        idle(3);
        step(1'b0, 1'b1, 16'h1234, 4'b1000, 4'b1111, 4'b0000);
        idle(RD * ND + 3);

        // Blink attribute on digit 1 over six scans from a fresh reset.
        step(1'b1, 1'b0, '0, '0, '0, '0);
        step(1'b0, 1'b1, 16'h89DE, 4'b0000, 4'b1111, 4'b0010);
        idle(6 * RD * ND);

        // LOAD held high with changing data.
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b1, VW'($urandom), ND'($urandom), ND'($urandom) | ND'($urandom), ND'($urandom));

        // Randomised traffic with sporadic loads and resets.
        for (int i = 0; i < 900; i++)
            step($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0, VW'($urandom),
                 ND'($urandom), ND'($urandom) | ND'($urandom), ND'($urandom));

        @(posedge CLK);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs never checked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
